// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_WIDTH data bits (LSB first), optional parity, stop.
// Define UART_TX_TWO_STOP_EN for two stop bits per frame.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Gray-coded so adjacent transitions flip a single state bit
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b010,
    STOP   = 3'b110
  } state_t;

  state_t                  state, next_state;
  logic [CNT_W-1:0]        count, next_count;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    load_c;
  logic                    tx_next_c;
  logic                    busy_next_c;
  logic                    stop_done_c;

`ifdef UART_TX_TWO_STOP_EN
  assign stop_done_c = (count == CNT_W'(1));
`else
  assign stop_done_c = 1'b1;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // Frame payload latched on acceptance; line outputs registered from current state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      TX_OUT <= tx_next_c;
      busy   <= busy_next_c;
      if (load_c) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
      end
    end
  end

  // Next-state, counter and output mux
  always_comb begin
    next_state  = IDLE;
    next_count  = '0;
    load_c      = 1'b0;
    tx_next_c   = 1'b1;
    busy_next_c = 1'b0;
    case (state)
      IDLE: begin
        if (Data_Valid) begin
          load_c     = 1'b1;
          next_state = START;
        end
      end
      START: begin
        tx_next_c   = 1'b0;
        busy_next_c = 1'b1;
        next_state  = DATA;
      end
      DATA: begin
        tx_next_c   = data_q[count];
        busy_next_c = 1'b1;
        if (count == LAST_BIT) begin
          next_state = par_en_q ? PARITY : STOP;
        end else begin
          next_state = DATA;
          next_count = count + CNT_W'(1);
        end
      end
      PARITY: begin
        tx_next_c   = par_bit_q;
        busy_next_c = 1'b1;
        next_state  = STOP;
      end
      STOP: begin
        busy_next_c = 1'b1;
        if (!stop_done_c) begin
          next_state = STOP;
          next_count = count + CNT_W'(1);
        end else if (Data_Valid) begin
          load_c     = 1'b1;
          next_state = START;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed scenarios plus randomized traffic
// against a bit-queue model of the serial line. Honours UART_TX_TWO_STOP_EN.
module tb_uart_tx_frame;

  localparam int unsigned DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int unsigned STOPS = 2;
`else
  localparam int unsigned STOPS = 1;
`endif
  localparam int unsigned LEN_PAR   = 1 + DW + 1 + STOPS;
  localparam int unsigned LEN_NOPAR = 1 + DW + STOPS;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          TX_OUT;
  logic          busy;

  int vectors = 0;
  int errors  = 0;
  bit exp_q[$];

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Line model: queue of bits still to appear; a request is taken when at most the final stop bit remains
  task automatic tick(output logic etx, output logic eb);
    logic [DW-1:0] d;
    logic pe, pt, dv;
    int unsigned pending;
    d = P_DATA; pe = PAR_EN; pt = PAR_TYP; dv = Data_Valid;
    @(posedge CLK);
    if (!RST) begin
      exp_q.delete();
      etx = 1'b1;
      eb  = 1'b0;
    end else begin
      pending = exp_q.size();
      eb  = (pending != 0);
      etx = (pending != 0) ? exp_q.pop_front() : 1'b1;
      if (dv && pending <= 1) begin
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back((^d) ^ pt);
        for (int i = 0; i < STOPS; i++) exp_q.push_back(1'b1);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic etx, eb;
    RST = 1'b0; Data_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(etx, eb);
      vectors++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc %0d: TX_OUT=%b busy=%b, want 1/0", i, TX_OUT, busy);
      end
    end
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(etx, eb);
      vectors++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0 || etx !== 1'b1 || eb !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc %0d: TX_OUT=%b busy=%b, want 1/0", i, TX_OUT, busy);
      end
    end
  endtask

  task automatic test_parity_a5();
    logic etx, eb;
    logic a5_seq [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int busy_cnt = 0;
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    tick(etx, eb);
    Data_Valid = 1'b0;
    for (int i = 0; i < LEN_PAR + 3; i++) begin
      tick(etx, eb);
      if (busy === 1'b1) busy_cnt++;
      vectors++;
      if (TX_OUT !== etx || busy !== eb) begin
        errors++;
        $display("FAIL a5_model cyc %0d: TX_OUT=%b busy=%b, want %b/%b", i, TX_OUT, busy, etx, eb);
      end
      if (i < 11) begin
        vectors++;
        if (TX_OUT !== a5_seq[i]) begin
          errors++;
          $display("FAIL a5_seq bit %0d: TX_OUT=%b, want %b", i, TX_OUT, a5_seq[i]);
        end
      end
    end
    vectors++;
    if (busy_cnt != int'(LEN_PAR)) begin
      errors++;
      $display("FAIL a5_busy_len: got %0d, want %0d", busy_cnt, LEN_PAR);
    end
  endtask

  task automatic test_parity_3c();
    logic etx, eb;
    logic nopar_seq [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int busy_cnt = 0;
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    tick(etx, eb);
    Data_Valid = 1'b0;
    for (int i = 0; i < LEN_PAR + 2; i++) begin
      tick(etx, eb);
      vectors++;
      if (TX_OUT !== etx || busy !== eb) begin
        errors++;
        $display("FAIL 3c_odd cyc %0d: TX_OUT=%b busy=%b, want %b/%b", i, TX_OUT, busy, etx, eb);
      end
      if (i == 9) begin
        vectors++;
        if (TX_OUT !== 1'b1) begin
          errors++;
          $display("FAIL 3c_odd_parity: TX_OUT=%b, want 1", TX_OUT);
        end
      end
    end
    PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    tick(etx, eb);
    Data_Valid = 1'b0;
    for (int i = 0; i < LEN_NOPAR + 2; i++) begin
      tick(etx, eb);
      if (busy === 1'b1) busy_cnt++;
      vectors++;
      if (TX_OUT !== etx || busy !== eb) begin
        errors++;
        $display("FAIL 3c_nopar cyc %0d: TX_OUT=%b busy=%b, want %b/%b", i, TX_OUT, busy, etx, eb);
      end
      if (i < 10) begin
        vectors++;
        if (TX_OUT !== nopar_seq[i]) begin
          errors++;
          $display("FAIL 3c_nopar_seq bit %0d: TX_OUT=%b, want %b", i, TX_OUT, nopar_seq[i]);
        end
      end
    end
    vectors++;
    if (busy_cnt != int'(LEN_NOPAR)) begin
      errors++;
      $display("FAIL 3c_busy_len: got %0d, want %0d", busy_cnt, LEN_NOPAR);
    end
  endtask

  task automatic test_back_to_back();
    logic etx, eb;
    logic [DW-1:0] rx = '0;
    int busy_low = 0;
    P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    tick(etx, eb);
    for (int i = 0; i < 2 * LEN_NOPAR + 2; i++) begin
      if (i == LEN_NOPAR - 1) P_DATA = 8'h0F;
      tick(etx, eb);
      if (i == LEN_NOPAR - 1) Data_Valid = 1'b0;
      if (i < 2 * LEN_NOPAR && busy !== 1'b1) busy_low++;
      if (i > LEN_NOPAR && i <= LEN_NOPAR + DW) rx[i - LEN_NOPAR - 1] = TX_OUT;
      vectors++;
      if (TX_OUT !== etx || busy !== eb) begin
        errors++;
        $display("FAIL b2b cyc %0d: TX_OUT=%b busy=%b, want %b/%b", i, TX_OUT, busy, etx, eb);
      end
      if (i == LEN_NOPAR) begin
        vectors++;
        if (TX_OUT !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gap: TX_OUT=%b after stop, want 0", TX_OUT);
        end
      end
    end
    vectors++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL b2b_busy: busy low %0d cycles, want 0", busy_low);
    end
    vectors++;
    if (rx !== 8'h0F) begin
      errors++;
      $display("FAIL b2b_data: got %h, want 0f", rx);
    end
  endtask

  task automatic test_disturb();
    logic etx, eb;
    P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    tick(etx, eb);
    Data_Valid = 1'b0;
    for (int i = 0; i < LEN_PAR + 5; i++) begin
      if (i == 3) begin
        P_DATA = DW'($urandom); PAR_EN = 1'b0; PAR_TYP = 1'b1; Data_Valid = 1'b1;
      end
      tick(etx, eb);
      if (i == 3) Data_Valid = 1'b0;
      vectors++;
      if (TX_OUT !== etx || busy !== eb) begin
        errors++;
        $display("FAIL disturb cyc %0d: TX_OUT=%b busy=%b, want %b/%b", i, TX_OUT, busy, etx, eb);
      end
      if (i == 9 || i >= LEN_PAR) begin
        vectors++;
        if (TX_OUT !== (i >= LEN_PAR) || busy !== (i < LEN_PAR)) begin
          errors++;
          $display("FAIL disturb_fixed cyc %0d: TX_OUT=%b busy=%b", i, TX_OUT, busy);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic etx, eb;
    int busy_cnt = 0;
    P_DATA = 8'h00; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    tick(etx, eb);
    Data_Valid = 1'b0;
    for (int i = 0; i < 5; i++) tick(etx, eb);
    #2;
    RST = 1'b0;
    #1;
    vectors++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: TX_OUT=%b busy=%b, want 1/0", TX_OUT, busy);
    end
    for (int i = 0; i < 2; i++) begin
      tick(etx, eb);
      vectors++;
      if (TX_OUT !== etx || busy !== eb) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: TX_OUT=%b busy=%b, want %b/%b", i, TX_OUT, busy, etx, eb);
      end
    end
    RST = 1'b1;
    P_DATA = 8'h81; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    tick(etx, eb);
    Data_Valid = 1'b0;
    for (int i = 0; i < LEN_PAR + 2; i++) begin
      tick(etx, eb);
      if (busy === 1'b1) busy_cnt++;
      vectors++;
      if (TX_OUT !== etx || busy !== eb) begin
        errors++;
        $display("FAIL post_reset cyc %0d: TX_OUT=%b busy=%b, want %b/%b", i, TX_OUT, busy, etx, eb);
      end
    end
    vectors++;
    if (busy_cnt != int'(LEN_PAR)) begin
      errors++;
      $display("FAIL post_reset_len: got %0d, want %0d", busy_cnt, LEN_PAR);
    end
  endtask

  task automatic test_random();
    logic etx, eb;
    for (int i = 0; i < 400; i++) begin
      P_DATA     = DW'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      Data_Valid = ($urandom_range(0, 3) == 0);
      tick(etx, eb);
      vectors++;
      if (TX_OUT !== etx || busy !== eb) begin
        errors++;
        $display("FAIL random cyc %0d: TX_OUT=%b busy=%b, want %b/%b", i, TX_OUT, busy, etx, eb);
      end
    end
    Data_Valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_parity_a5();
    test_parity_3c();
    test_back_to_back();
    test_disturb();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Transmit-side UART framer. Accepts one parallel byte per frame from the register-file/async-FIFO side and serialises it onto TX_OUT as start, data, optional parity and stop bits. It is the transmit counterpart of the receive FSM. It runs on the divided UART TX clock, one serial bit per CLK cycle, so there is no internal oversampling. Control FSM, serializer, parity generator and output mux are contained in this one block.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; shifted out LSB first.

Ports:
CLK  input  1  UART TX clock; one bit time per cycle.
RST  input  1  asynchronous active-low reset.
P_DATA  input  DATA_WIDTH  parallel byte to send; sampled only on acceptance.
Data_Valid  input  1  request to send P_DATA; level, checked on acceptance cycles only.
PAR_EN  input  1  1 = parity bit inserted between data and stop.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
TX_OUT  output  1  serial line; idle high.
busy  output  1  high while a frame is in flight; upstream must hold the next request until busy is low or the frame is in STOP.

Behaviour:
- Reset (async, RST=0): state IDLE, TX_OUT=1, busy=0, bit counter=0, shift/config registers cleared. Reset mid-frame aborts immediately and the line returns high with no partial stop bit.
- All outputs are registered. There are no combinational paths from inputs to TX_OUT or busy.
- FSM states: IDLE, START, DATA, PARITY, STOP (Gray-coded like the RX FSM).
- Acceptance: when state is IDLE or STOP and Data_Valid=1 at a CLK edge:
  - P_DATA, PAR_EN and PAR_TYP are latched.
  - Parity is computed from the latched data: XOR of all bits for even, inverted for odd.
  - Next state is START.
- Data_Valid in any other state is ignored. No queueing and no error flag.
- Config and data changes mid-frame do not affect the frame in flight.
- START: TX_OUT=0 for exactly 1 cycle, then DATA.
- DATA: TX_OUT = latched bit[count], LSB first, for DATA_WIDTH cycles. The counter runs 0..DATA_WIDTH-1. At count DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = parity bit for 1 cycle, then STOP.
- STOP: TX_OUT=1 for 1 cycle. Then IDLE if no acceptance, or START if accepted (back-to-back frames with zero idle gap).
- busy:
  - Goes 1 on the cycle TX_OUT first goes 0 (START).
  - Stays 1 through STOP.
  - Drops to 0 on entry to IDLE.
  - Stays 1 continuously across back-to-back frames.
- Latency: Data_Valid sampled at edge N, so the start bit appears on TX_OUT after edge N+1's update, i.e. visible for cycle N+1.
- Frame length: 1 + DATA_WIDTH + PAR_EN + 1 cycles, i.e. 11 with parity and 10 without for DATA_WIDTH=8.
- Illegal or unused state encodings: next state IDLE, TX_OUT=1, busy=0.

Optional Feature:
Macro UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 cycles, counted with the bit counter. Acceptance is allowed only in the second stop cycle (and in IDLE). Frame length becomes 12 with parity and 11 without. busy stays high through both stop cycles.
- Undefined: a single stop cycle as above. No extra logic is present.

Test Plan:
1. Reset then idle: RST low for 3 cycles, then high with Data_Valid=0 for 20 cycles -> TX_OUT=1 and busy=0 throughout.
2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, single Data_Valid pulse -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity even),1. busy high for exactly 11 cycles.
3. P_DATA=0x3C, PAR_EN=1, PAR_TYP=1 -> parity bit 1. With PAR_EN=0 -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1 and no parity bit.
4. Back-to-back: Data_Valid held high with 0x55 then 0x0F presented in the STOP cycle -> second start bit immediately follows first stop bit with no idle cycle. busy never drops. Second frame carries 0x0F.
5. Mid-frame disturbance: change P_DATA, PAR_EN and PAR_TYP and pulse Data_Valid during DATA of a 0xFF frame -> current frame unchanged; request ignored; line idles after STOP.
6. Reset mid-frame: assert RST during DATA bit 3 of 0x00 -> TX_OUT=1 and busy=0 asynchronously. After release, a new 0x81 frame transmits correctly. With UART_TX_TWO_STOP_EN defined, the frame is 12 cycles and ends 1,1.
